muldiv_hilo_unit: RTL and testbench
===================================

# muldiv_hilo_unit

Multicycle multiply/divide sequencer with architectural HI/LO registers for the MIPS core. It takes MULT/MULTU/DIV/DIVU operands from the execute stage and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. Results are held in HI/LO, and the unit raises a stall request to the pipeline while results are pending. The single-cycle ULA keeps 32-bit ops; 64-bit/HI-LO work moves here.

## Interface
- WIDTH, 32, operand width; HI/LO each WIDTH bits
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch operation (accepted only in IDLE)
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  multiplicand / dividend
- rt_val  in  WIDTH  multiplier / divisor
- mthi, mtlo  in  1  write wdata into HI / LO (accepted only in IDLE)
- wdata  in  WIDTH  MTHI/MTLO data
- rd_req  in  1  execute stage holds MFHI/MFLO
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse; HI/LO hold new result
- div_by_zero  out  1  pulses with done when a DIV/DIVU had rt_val == 0
- stall  out  1  (rd_req | start | mthi | mtlo) & busy
- hi, lo  out  WIDTH  architectural HI/LO

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: start=1 latches op, operands, and sign flags (signed ops only); stores magnitudes; count=0 -> CALC.
- CALC: one iteration per cycle; count increments; at count==WIDTH-1 -> FIX.
- Multiply: 2*WIDTH-bit accumulator, shift-add on magnitudes.
- Divide: restoring; partial remainder WIDTH+1 bits; one quotient bit per cycle.
- FIX: sign correction for signed ops, then HI/LO write -> DONE.
  - MULT: product negated if sign(rs) != sign(rt).
  - DIV: quotient negated if signs differ; remainder takes sign of dividend.
- Final assignment: multiply HI=product[2W-1:W], LO=product[W-1:0]; divide LO=quotient, HI=remainder.
- Divide by zero (either signedness): LO=all ones, HI=rs_val unchanged, no sign fix, div_by_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000 (wraps), HI=0; no flag.
- DONE: done=1 for one cycle -> IDLE.
- mthi/mtlo in IDLE write on that edge. If they coincide with start, the write occurs and the later result overwrites it.
- start/mthi/mtlo while busy are ignored; the pipeline must honour stall.
- rd_req only drives stall; reading hi/lo is always combinational from the registers.

## Timing
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, count=0. Mid-operation reset aborts with no HI/LO update.
- start sampled at edge E0. busy=1 after E0. CALC occupies edges E1..EW.
- E(W+1) enters DONE and writes HI/LO.
- done/div_by_zero are high between E(W+1) and E(W+2). IDLE follows E(W+2).
- For W=32: 34 cycles start-to-done; new start accepted at E(W+2)+1 at the earliest (35 cycles issue-to-issue).
- stall is combinational from the inputs and the registered state; no input-to-output path other than stall.
- HI/LO change only at the FIX->DONE edge or on an accepted mthi/mtlo.

## Structure
- Shared package mips_pkg:
  - muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - muldiv_state_t enum (IDLE, CALC, FIX, DONE)
  - MIPS_WIDTH = 32
- Sub-module muldiv_step: combinational single iteration.
  - Shift-add step or restore/subtract step selected by is_div.
  - Instantiated once; the FSM, counter, sign flags, and HI/LO live in the top.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=5 -> after 34 cycles done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 34 cycles.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU 10/0 -> lo=0xFFFFFFFF, hi=0x0000000A, div_by_zero=1 coincident with done.
- Second start and mthi during CALC with rd_req=1 -> both ignored, stall=1 throughout; the first result is unaffected. mtlo=0x1234 in IDLE -> lo=0x1234 the next cycle.
- rst_n low at cycle 10 of a MULT with hi=lo=0xAAAA beforehand -> hi=lo=0 immediately, busy=0, no done pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: multiply/divide opcodes, sequencer states and the
// architectural datapath width.
package mips_pkg;

  localparam int MIPS_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide sequencer: a shift-add
// multiply step or a restoring-divide step, selected by is_div.
module muldiv_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MIPS_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH:0]   upper_next,
  output logic [WIDTH-1:0] lower_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  // Multiply: upper/lower form the product accumulator, shifted right each step.
  // Divide: upper is the partial remainder, lower shifts dividend out, quotient in.
  always_comb begin
    sum     = upper + (lower[0] ? {1'b0, operand} : '0);
    shifted = {upper[WIDTH-1:0], lower[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, operand};
    if (is_div) begin
      upper_next = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      lower_next = {lower[WIDTH-2:0], ~diff[WIDTH+1]};
    end else begin
      upper_next = {1'b0, sum[WIDTH:1]};
      lower_next = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO
// registers; requests a pipeline stall while a result is pending.
module muldiv_hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = MIPS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state, state_next;
  muldiv_op_t    op_q;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     upper_q, upper_next;
  logic [WIDTH-1:0]   lower_q, lower_next, operand_q, rs_raw_q, hi_q, lo_q;
  logic               neg_q, rem_neg_q, dbz_q, is_div_q;
  logic               in_div, in_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] product;

  always_comb begin
    in_div    = op[1];
    in_signed = ~op[0];
    rs_neg    = in_signed & rs_val[WIDTH-1];
    rt_neg    = in_signed & rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;
  end

  assign is_div_q = (op_q == MD_DIV) || (op_q == MD_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div     (is_div_q),
    .upper      (upper_q),
    .lower      (lower_q),
    .operand    (operand_q),
    .upper_next (upper_next),
    .lower_next (lower_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign fix-up; a zero divisor bypasses it and returns the raw dividend in HI.
  always_comb begin
    product = {upper_q[WIDTH-1:0], lower_q};
    fix_hi  = '0;
    fix_lo  = '0;
    if (!is_div_q) begin
      {fix_hi, fix_lo} = neg_q ? -product : product;
    end else if (dbz_q) begin
      fix_hi = rs_raw_q;
      fix_lo = '1;
    end else begin
      fix_lo = neg_q ? -lower_q : lower_q;
      fix_hi = rem_neg_q ? -upper_q[WIDTH-1:0] : upper_q[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MD_MULT;
      count     <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
      rs_raw_q  <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
          if (start) begin
            op_q      <= muldiv_op_t'(op);
            count     <= '0;
            upper_q   <= '0;
            lower_q   <= in_div ? rs_mag : rt_mag;
            operand_q <= in_div ? rt_mag : rs_mag;
            rs_raw_q  <= rs_val;
            neg_q     <= rs_neg ^ rt_neg;
            rem_neg_q <= rs_neg;
            dbz_q     <= in_div & (rt_val == '0);
          end
        end
        CALC: begin
          count   <= count + CW'(1);
          upper_q <= upper_next;
          lower_q <= lower_next;
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) & dbz_q;
  assign stall       = (rd_req | start | mthi | mtlo) & busy;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: an arithmetic reference model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_muldiv_hilo_unit;

  localparam int LATENCY = 34;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, mthi = 1'b0, mtlo = 1'b0, rd_req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
  logic        busy, done, div_by_zero, stall;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  muldiv_hilo_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .wdata       (wdata),
    .rd_req      (rd_req),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .stall       (stall),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference result as {div_by_zero, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [64:0] modelResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = sa * sb; return {1'b0, 64'(p)}; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; return {1'b0, u}; end
      2'b10: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  int          m_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [64:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_hi  = '0;
      m_lo  = '0;
    end else if (m_cnt == 0) begin
      if (mthi) m_hi = wdata;
      if (mtlo) m_lo = wdata;
      if (start) begin
        m_res = modelResult(op, rs_val, rt_val);
        m_cnt = LATENCY;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        m_hi = m_res[63:32];
        m_lo = m_res[31:0];
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    checkOutput("cyc_busy",  32'(busy),        32'(m_cnt != 0));
    checkOutput("cyc_done",  32'(done),        32'(m_cnt == 1));
    checkOutput("cyc_dbz",   32'(div_by_zero), 32'((m_cnt == 1) && m_res[64]));
    checkOutput("cyc_stall", 32'(stall),       32'((rd_req | start | mthi | mtlo) && (m_cnt != 0)));
    checkOutput("cyc_hi",    hi,               m_hi);
    checkOutput("cyc_lo",    lo,               m_lo);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic mh, input logic [31:0] wd);
    @(negedge clk);
    op     = o;
    rs_val = a;
    rt_val = b;
    mthi   = mh;
    wdata  = wd;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mthi   = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int cyc;
    applyStimulus(o, a, b, 1'b0, 32'h0);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({name, "_latency"}, 32'(cyc), 32'(LATENCY));
    checkOutput({name, "_hi"}, hi, exp_hi);
    checkOutput({name, "_lo"}, lo, exp_lo);
    checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
    @(negedge clk);
    checkOutput({name, "_idle"}, 32'(busy), 32'(0));
    checkOutput({name, "_done_once"}, 32'(done), 32'(0));
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi",   hi,                32'h0);
    checkOutput("reset_lo",   lo,                32'h0);
    checkOutput("reset_busy", 32'(busy),         32'(0));
    checkOutput("reset_done", 32'(done),         32'(0));
    checkOutput("reset_dbz",  32'(div_by_zero),  32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    runOp("mult_neg",   2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    runOp("multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    runOp("div_neg",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("div_negdiv", 2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    runOp("div_wrap",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    runOp("divu_small", 2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0);
    runOp("divu_zero",  2'b11, 32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, 1'b1);
    runOp("div_zero",   2'b10, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);

    // mthi coinciding with start lands first, then the product replaces it.
    applyStimulus(2'b01, 32'h1234_5678, 32'h10, 1'b1, 32'h5555);
    checkOutput("mthi_with_start", hi, 32'h5555);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mthi_start_hi", hi, 32'h1);
    checkOutput("mthi_start_lo", lo, 32'h2345_6780);
    @(negedge clk);

    // Requests during CALC are ignored and hold stall high.
    applyStimulus(2'b00, 32'd6, 32'd7, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd3;
    mthi = 1'b1; wdata = 32'hDEAD; rd_req = 1'b1;
    cyc = 4;
    while (!done && cyc < 60) begin
      #1;
      checkOutput("busy_stall", 32'(stall), 32'(1));
      @(negedge clk);
      cyc++;
    end
    #1;
    checkOutput("busy_stall_done", 32'(stall), 32'(1));
    checkOutput("busy_ignored_hi", hi, 32'h0);
    checkOutput("busy_ignored_lo", lo, 32'd42);
    start = 1'b0; mthi = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    checkOutput("busy_no_relaunch", 32'(busy), 32'(0));

    mtlo = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mtlo = 1'b0;
    checkOutput("mtlo_lo", lo, 32'h1234);
    checkOutput("mtlo_hi_kept", hi, 32'h0);

    // Abort a MULT mid-flight with reset.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAAAA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checkOutput("pre_reset_hi", hi, 32'hAAAA);
    checkOutput("pre_reset_lo", lo, 32'hAAAA);
    applyStimulus(2'b00, 32'd3, 32'd4, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_hi",   hi,        32'h0);
    checkOutput("abort_lo",   lo,        32'h0);
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("after_reset", 2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
